// File: rtl/rf_writeback_pkg.sv
// rf_writeback_pkg: shared ISA constants (datapath width, load funct3 encodings)
package rf_writeback_pkg;
  localparam int ISA_WIDTH = 32;
  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } ld_funct3_e;
endpackage

// File: rtl/rf_writeback_load_extend.sv
// load_extend: selects the loaded byte/halfword/word and sign- or zero-extends it
module load_extend
  import rf_writeback_pkg::*;
#(
  parameter int XLEN = ISA_WIDTH
) (
  input  logic [XLEN-1:0] lsu_data,
  input  logic [2:0]      lsu_funct3,
  input  logic [1:0]      lsu_off,
  output logic [XLEN-1:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  // pick the addressed lane, then extend; unknown funct3 falls through to the full word
  always_comb begin
    b = 8'(lsu_data >> {lsu_off, 3'b000});
    h = 16'(lsu_data >> {lsu_off[1], 4'b0000});
    result = lsu_funct3 == LD_LB  ? {{(XLEN-8){b[7]}}, b} :
             lsu_funct3 == LD_LBU ? {{(XLEN-8){1'b0}}, b} :
             lsu_funct3 == LD_LH  ? {{(XLEN-16){h[15]}}, h} :
             lsu_funct3 == LD_LHU ? {{(XLEN-16){1'b0}}, h} : lsu_data;
  end
endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: arbitrates ALU/LSU results into one registered register-file write port and keeps the pending-write scoreboard
module rf_writeback
  import rf_writeback_pkg::*;
#(
  parameter int XLEN = ISA_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            issue_ready,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic [2:0]      lsu_funct3,
  input  logic [1:0]      lsu_off,
  output logic            wr_en,
  output logic [4:0]      wr_addr,
  output logic [XLEN-1:0] wr_data,
  output logic [31:0]     busy
);
  logic [XLEN-1:0] ld_data, sel_data;
  logic [4:0]      sel_rd;
  logic            sel_v;
  logic [31:0]     set_m, clr_m;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .lsu_data  (lsu_data),
    .lsu_funct3(lsu_funct3),
    .lsu_off   (lsu_off),
    .result    (ld_data)
  );

  assign issue_ready = issue_rd == 5'd0 || !busy[issue_rd];
  assign alu_ready   = ~lsu_valid;
  assign lsu_ready   = 1'b1;

  // LSU has fixed priority; scoreboard set/clear masks for this edge
  always_comb begin
    sel_v    = lsu_valid | alu_valid;
    sel_rd   = lsu_valid ? lsu_rd : alu_rd;
    sel_data = lsu_valid ? ld_data : alu_data;
    clr_m    = wr_en ? 32'd1 << wr_addr : 32'd0;
    set_m    = (issue_valid && issue_ready) ? 32'd1 << issue_rd : 32'd0;
  end

  // write port register; x0 requests are consumed without a strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= sel_v && sel_rd != 5'd0;
      if (sel_v && sel_rd != 5'd0) begin
        wr_addr <= sel_rd;
        wr_data <= sel_data;
      end
    end
  end

  // scoreboard: a new issue outranks the retiring write to the same register; bit 0 never sets
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else busy <= ((busy & ~clr_m) | set_m) & ~32'd1;
  end
endmodule

// File: doc/rf_writeback.md
# rf_writeback

Write-back unit for the register file: the store side of the register-file interface. It arbitrates result writes from the ALU and the load/store unit and applies load byte/halfword extraction and sign/zero extension. It drives a single registered write port (wr_en/wr_addr/wr_data) into the register file. It also maintains the 32-entry pending-write scoreboard that issue logic consults before reading source registers.

## Interface
- XLEN, default `ISA_WIDTH (32): datapath width.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  an instruction with destination issue_rd is issued this cycle.
- issue_rd  in  5  destination register of issuing instruction.
- issue_ready  out  1  combinational: issue_rd==0 or busy[issue_rd]==0.
- alu_valid  in  1  ALU result available.
- alu_ready  out  1  ALU result accepted when alu_valid & alu_ready.
- alu_rd  in  5  ALU destination.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  load data available.
- lsu_ready  out  1  always 1 (LSU has fixed priority).
- lsu_rd  in  5  load destination.
- lsu_data  in  XLEN  raw aligned memory word.
- lsu_funct3  in  3  load kind: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- lsu_off  in  2  byte offset of load address.
- wr_en  out  1  register-file write strobe (registered).
- wr_addr  out  5  register-file write address (registered).
- wr_data  out  XLEN  register-file write data (registered).
- busy  out  32  scoreboard: bit n = write to xn pending.

## Operation
- Arbitration: fixed priority, LSU over ALU. lsu_ready=1. alu_ready = ~lsu_valid. An ALU result never stalls the LSU, and the ALU holds valid/rd/data stable until accepted.
- Accepted request with rd≠0: wr_en=1, wr_addr=rd, and wr_data=result on the next cycle.
- Accepted request with rd==0: consumed, wr_en stays 0, and the scoreboard is untouched. x0 is never written.
- Load extraction:
  - LB/LBU take byte lsu_data[8*off+7:8*off].
  - LH/LHU take halfword [16*off[1]+15:16*off[1]]; off[0] is ignored and misalignment is not checked.
  - LW takes the full word.
  - LB/LH sign-extend to XLEN; LBU/LHU zero-extend.
  - Undefined funct3 (011, 110, 111) is treated as LW.
- Scoreboard:
  - issue_valid with issue_rd≠0 sets busy[issue_rd].
  - The cycle holding wr_en=1 clears busy[wr_addr] at its closing edge.
  - Set and clear of the same bit on the same edge: set wins, because the newer issue owns the register.
  - busy[0] is constant 0.
- Issue to a busy register is the issuer's responsibility: issue_ready must be checked. issue_valid while issue_ready=0 is ignored (no state change).

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0. alu_ready follows lsu_valid combinationally even during reset.
- Latency: request accepted in cycle N → wr_en/wr_addr/wr_data valid in cycle N+1. The register-file write lands at the end of N+1, and busy bit clear is visible in N+2, when the register file already holds the value.
- Throughput: one write per cycle. Back-to-back accepts produce consecutive wr_en cycles.
- Simultaneous alu_valid & lsu_valid: LSU is written in N+1. The ALU is accepted in N+1 at the earliest (if lsu_valid is low then) and written in N+2.
- Reset mid-operation: the pending output register and all busy bits clear immediately, and in-flight results are dropped.
- No combinational path from any input to wr_* or busy. The only combinational outputs are alu_ready and issue_ready.

## Structure
- Load funct3 encodings (LB/LH/LW/LBU/LHU) go in the shared ISA constants header alongside `ISA_WIDTH, for reuse by decoder and LSU.
- Sub-module load_extend (combinational: lsu_data, lsu_funct3, lsu_off → XLEN result), instantiated once.
- Arbitration, output register and scoreboard stay in rf_writeback.

## Test plan
- Reset: assert rst_n=0 mid-write with busy=0x0000_0006 → wr_en=0, wr_data=0, busy=0 immediately.
- ALU write: issue x5, then alu_valid rd=5 data=0xDEADBEEF in cycle N → wr_en=1, wr_addr=5, wr_data=0xDEADBEEF in N+1; busy[5]=1 until N+2, then 0; issue_ready for x5 low until N+2.
- Contention: alu_valid (rd=3, 0x11) and lsu_valid (rd=4, LW 0x22) in the same cycle → alu_ready=0; x4←0x22 in N+1 and x3←0x11 in N+2.
- Extension: lsu_data=0x80FF7F01 with LB off=3 → 0xFFFFFF80; LBU off=3 → 0x00000080; LH off=2 → 0xFFFF80FF; LHU off=0 → 0x00007F01; funct3=111 → 0x80FF7F01.
- x0 and set/clear race: write to rd=0 → wr_en stays 0. A write commits x7 while issue_valid rd=7 arrives in the same cycle → busy[7] stays 1.
